// File: rtl/kuuga_simple_cache_top.sv
// rtl/kuuga_simple_cache_top.sv - read generator, direct-mapped single-word cache and fixed-latency ROM
// Optional hit/miss statistics counters: define KUUGA_SC_STATS_EN.
`timescale 1ns/1ps
module kuuga_simple_cache_top #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int LINES       = 16,
    parameter int MEM_LATENCY = 4,
    parameter int N_REQ       = 64,
    parameter int LOOP_LEN    = 16
) (
    input  logic sys_diff_clock_clk_p,
    input  logic sys_diff_clock_clk_n,
    input  logic reset
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int CNT_W = $clog2(N_REQ + 1);

    typedef enum logic [1:0] {IDLE, MISS_WAIT, FILL} state_t;

    logic w_clk;
    logic w_rst_n;
    assign w_clk   = sys_diff_clock_clk_p;
    assign w_rst_n = reset;

    // Generator
    logic              r_busy;
    logic [ADDR_W-1:0] r_gen_addr;
    logic [CNT_W-1:0]  r_rsp_cnt;
    logic              done;
    logic              w_req_valid;

    // Cache
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];
    logic [DATA_W-1:0] r_fill_data;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_mem_req;
    logic              w_accept;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic [IDX_W-1:0]  w_fill_idx;
    logic              w_hit_rsp;
    logic              w_miss_rsp;

    // Backing ROM
    logic [MEM_LATENCY-1:0] r_mem_vld;
    logic [ADDR_W-1:0]      r_mem_addr [MEM_LATENCY];
    logic                   w_mem_rvalid;
    logic [ADDR_W-1:0]      w_rom_addr;
    logic [DATA_W-1:0]      w_mem_rdata;

    // Statistics
    logic [15:0]       hit_count;
    logic [15:0]       miss_count;
    logic [DATA_W-1:0] checksum;

    assign w_req_valid = !r_busy && !done;
    assign w_accept    = w_req_valid && (r_state == IDLE);
    assign w_idx       = r_gen_addr[IDX_W-1:0];
    assign w_tag       = r_gen_addr[ADDR_W-1:IDX_W];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill_idx  = r_addr[IDX_W-1:0];
    assign w_hit_rsp   = w_accept && w_hit;
    assign w_miss_rsp  = (r_state == MISS_WAIT) && w_mem_rvalid;

    assign w_mem_rvalid = r_mem_vld[MEM_LATENCY-1];
    assign w_rom_addr   = r_mem_addr[MEM_LATENCY-1];
    assign w_mem_rdata  = DATA_W'({~w_rom_addr[15:0], w_rom_addr[15:0]});

    // One request outstanding; the next is offered the cycle after its response.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_busy     <= 1'b0;
            r_gen_addr <= '0;
            r_rsp_cnt  <= '0;
            done       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_busy     <= 1'b1;
                r_gen_addr <= (r_gen_addr == ADDR_W'(LOOP_LEN - 1)) ? '0 : r_gen_addr + ADDR_W'(1);
            end else if (r_rsp_valid) begin
                r_busy <= 1'b0;
            end
            if (r_rsp_valid) begin
                r_rsp_cnt <= r_rsp_cnt + CNT_W'(1);
                if (r_rsp_cnt == CNT_W'(N_REQ - 1)) begin
                    done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_valid     <= '0;
            r_fill_data <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_mem_req   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_mem_req   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr <= r_gen_addr;
                        if (w_hit) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_data[w_idx];
                        end else begin
                            r_mem_req <= 1'b1;
                            r_state   <= MISS_WAIT;
                        end
                    end
                end
                MISS_WAIT: begin
                    if (w_mem_rvalid) begin
                        r_fill_data <= w_mem_rdata;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_mem_rdata;
                        r_state     <= FILL;
                    end
                end
                FILL: begin
                    r_valid[w_fill_idx] <= 1'b1;
                    r_state             <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line payload needs no reset: the valid bits gate every lookup.
    always_ff @(posedge w_clk) begin
        if (r_state == FILL) begin
            r_tag[w_fill_idx]  <= r_addr[ADDR_W-1:IDX_W];
            r_data[w_fill_idx] <= r_fill_data;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_mem_vld <= '0;
        end else begin
            r_mem_vld[0] <= r_mem_req;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_mem_vld[i] <= r_mem_vld[i-1];
            end
        end
    end

    always_ff @(posedge w_clk) begin
        r_mem_addr[0] <= r_addr;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            r_mem_addr[i] <= r_mem_addr[i-1];
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            checksum <= '0;
        end else if (w_hit_rsp) begin
            checksum <= checksum + r_data[w_idx];
        end else if (w_miss_rsp) begin
            checksum <= checksum + w_mem_rdata;
        end
    end

`ifdef KUUGA_SC_STATS_EN
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (w_hit_rsp && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (w_miss_rsp && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

    // Results are observed hierarchically; the negative clock leg is only needed by a real diff buffer.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, sys_diff_clock_clk_n, hit_count, miss_count, checksum, r_rsp_data};

endmodule

// File: tb/tb_kuuga_simple_cache_top.sv
// tb/tb_kuuga_simple_cache_top.sv - self-checking bench for kuuga_simple_cache_top
`timescale 1ns/1ps
module tb_kuuga_simple_cache_top;
    localparam int LAT   = 4;
    localparam int NREQ  = 64;
    localparam int LINES = 16;
`ifdef KUUGA_SC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk_p = 1'b0;
    logic clk_n;
    logic rst_a;
    logic rst_b;
    logic sel_b;
    int   checks = 0;
    int   errors = 0;

    int          first_lat;
    logic [31:0] first_data;
    int          a5_lat;
    logic [31:0] a5_data;
    bit          a5_memreq;

    always #5 clk_p = ~clk_p;
    assign clk_n = ~clk_p;

    kuuga_simple_cache_top #(.LOOP_LEN(16)) dut_a (
        .sys_diff_clock_clk_p (clk_p),
        .sys_diff_clock_clk_n (clk_n),
        .reset                (rst_a)
    );

    kuuga_simple_cache_top #(.LOOP_LEN(32)) dut_b (
        .sys_diff_clock_clk_p (clk_p),
        .sys_diff_clock_clk_n (clk_n),
        .reset                (rst_b)
    );

    wire        m_accept    = sel_b ? dut_b.w_accept    : dut_a.w_accept;
    wire        m_rsp_valid = sel_b ? dut_b.r_rsp_valid : dut_a.r_rsp_valid;
    wire [31:0] m_rsp_data  = sel_b ? dut_b.r_rsp_data  : dut_a.r_rsp_data;
    wire        m_mem_req   = sel_b ? dut_b.r_mem_req   : dut_a.r_mem_req;
    wire        m_done      = sel_b ? dut_b.done        : dut_a.done;
    wire [31:0] m_checksum  = sel_b ? dut_b.checksum    : dut_a.checksum;
    wire [15:0] m_hit       = sel_b ? dut_b.hit_count   : dut_a.hit_count;
    wire [15:0] m_miss      = sel_b ? dut_b.miss_count  : dut_a.miss_count;

    // Reference: sequential address stream through an ideal direct-mapped cache.
    task automatic run_check(input bit use_b, input int loop_len, output int cyc);
        bit          mv [LINES];
        int          mt [LINES];
        int          n_acc, cur, acc_cyc, exp_rsp, exp_cycles, a, li, tg, hits, misses;
        bit          exp_hit, memreq_seen;
        logic [31:0] exp_data, sum;
        n_acc = 0; cur = 0; acc_cyc = -10; exp_rsp = -1; exp_cycles = 0;
        hits = 0; misses = 0; exp_hit = 0; memreq_seen = 0; exp_data = '0; sum = '0;
        for (int i = 0; i < LINES; i++) begin
            mv[i] = 0;
            mt[i] = 0;
        end
        sel_b = use_b;
        #1;
        while (!m_done && cur < 2000) begin
            if (m_accept) begin
                a        = n_acc % loop_len;
                li       = a % LINES;
                tg       = a / LINES;
                exp_hit  = mv[li] && (mt[li] == tg);
                exp_data = 32'(longint'(65535 - a) * 65536 + longint'(a));
                exp_rsp  = cur + (exp_hit ? 1 : LAT + 2);
                acc_cyc  = cur;
                memreq_seen = 0;
                exp_cycles += exp_hit ? 2 : LAT + 3;
                if (exp_hit) begin
                    hits++;
                end else begin
                    misses++;
                    mv[li] = 1;
                    mt[li] = tg;
                end
                sum += exp_data;
                n_acc++;
            end
            if (m_mem_req) begin
                checks++;
                memreq_seen = 1;
                if (exp_hit || cur != acc_cyc + 1) begin
                    errors++;
                    $display("FAIL mem_req: seen at cycle %0d, required only at cycle %0d after a miss (hit=%0d)",
                             cur, acc_cyc + 1, exp_hit);
                end
            end
            if (m_rsp_valid) begin
                checks++;
                if (cur != exp_rsp || m_rsp_data !== exp_data) begin
                    errors++;
                    $display("FAIL rsp txn%0d: cycle %0d data %h, required cycle %0d data %h",
                             n_acc - 1, cur, m_rsp_data, exp_rsp, exp_data);
                end
                if (n_acc == 1) begin
                    first_lat  = cur - acc_cyc;
                    first_data = m_rsp_data;
                end
                if (n_acc == 22) begin
                    a5_lat    = cur - acc_cyc;
                    a5_data   = m_rsp_data;
                    a5_memreq = memreq_seen;
                end
                exp_rsp = -1;
            end
            @(posedge clk_p);
            #1;
            cur++;
        end
        cyc = cur;
        checks++;
        if (cur >= 2000) begin
            errors++;
            $display("FAIL done_timeout: done=%0d after %0d cycles, required done", m_done, cur);
        end
        checks++;
        if (cur != exp_cycles || n_acc != NREQ) begin
            errors++;
            $display("FAIL run_length: %0d cycles %0d requests, required %0d cycles %0d requests",
                     cur, n_acc, exp_cycles, NREQ);
        end
        checks++;
        if (m_checksum !== sum) begin
            errors++;
            $display("FAIL checksum_model: %h, required %h", m_checksum, sum);
        end
        checks++;
        if (m_hit !== 16'(STATS ? hits : 0) || m_miss !== 16'(STATS ? misses : 0)) begin
            errors++;
            $display("FAIL counters_model: hit %0d miss %0d, required hit %0d miss %0d",
                     m_hit, m_miss, STATS ? hits : 0, STATS ? misses : 0);
        end
        @(posedge clk_p);
        #1;
        checks++;
        if (m_accept || m_rsp_valid || !m_done) begin
            errors++;
            $display("FAIL quiet_after_done: accept %0d rsp %0d done %0d, required 0 0 1",
                     m_accept, m_rsp_valid, m_done);
        end
    endtask

    task automatic check_cleared(input string tag);
        checks++;
        if (dut_a.done !== 1'b0 || dut_a.checksum !== 32'h0 || dut_a.r_rsp_valid !== 1'b0 ||
            dut_a.r_mem_req !== 1'b0 || dut_a.r_valid !== 16'h0) begin
            errors++;
            $display("FAIL %s: done %0d checksum %h rsp %0d mem_req %0d valid %h, required all zero",
                     tag, dut_a.done, dut_a.checksum, dut_a.r_rsp_valid, dut_a.r_mem_req, dut_a.r_valid);
        end
        checks++;
        if (dut_a.hit_count !== 16'h0 || dut_a.miss_count !== 16'h0) begin
            errors++;
            $display("FAIL %s_counters: hit %0d miss %0d, required 0 0", tag, dut_a.hit_count, dut_a.miss_count);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        #49;
        check_cleared("reset_state");
        #1;
        rst_a = 1'b1;
    endtask

    task automatic test_full_run();
        int cyc;
        run_check(0, 16, cyc);
        checks++;
        if (cyc != 208 || dut_a.checksum !== 32'hFDE001E0) begin
            errors++;
            $display("FAIL default_totals: %0d cycles checksum %h, required 208 cycles checksum fde001e0",
                     cyc, dut_a.checksum);
        end
        checks++;
        if (dut_a.hit_count !== (STATS ? 16'd48 : 16'd0) || dut_a.miss_count !== (STATS ? 16'd16 : 16'd0)) begin
            errors++;
            $display("FAIL default_counters: hit %0d miss %0d", dut_a.hit_count, dut_a.miss_count);
        end
        checks++;
        if (first_lat != LAT + 2 || first_data !== 32'hFFFF0000) begin
            errors++;
            $display("FAIL first_request: latency %0d data %h, required %0d ffff0000", first_lat, first_data, LAT + 2);
        end
        checks++;
        if (a5_lat != 1 || a5_data !== 32'hFFFA0005 || a5_memreq) begin
            errors++;
            $display("FAIL second_pass_addr5: latency %0d data %h mem_req %0d, required 1 fffa0005 0",
                     a5_lat, a5_data, a5_memreq);
        end
    endtask

    task automatic test_reset_mid_miss();
        int k, seen, n, cyc;
        @(negedge clk_p);
        rst_a = 1'b0;
        @(negedge clk_p);
        rst_a = 1'b1;
        sel_b = 1'b0;
        #1;
        k = $urandom_range(2, 16);
        seen = 0;
        n = 0;
        while (seen < k && n < 2000) begin
            if (m_mem_req) seen++;
            if (seen < k) begin
                @(posedge clk_p);
                #1;
                n++;
            end
        end
        checks++;
        if (seen < k) begin
            errors++;
            $display("FAIL miss_search: %0d misses seen, required %0d", seen, k);
        end
        repeat ($urandom_range(0, LAT - 1)) @(posedge clk_p);
        @(negedge clk_p);
        rst_a = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk_p);
        @(negedge clk_p);
        check_cleared("mid_miss_reset");
        rst_a = 1'b1;
        run_check(0, 16, cyc);
        checks++;
        if (cyc != 208 || dut_a.checksum !== 32'hFDE001E0) begin
            errors++;
            $display("FAIL rerun_totals: %0d cycles checksum %h, required 208 fde001e0", cyc, dut_a.checksum);
        end
    endtask

    task automatic test_conflict();
        int cyc;
        @(negedge clk_p);
        rst_b = 1'b1;
        run_check(1, 32, cyc);
        checks++;
        if (cyc != 448 || dut_b.hit_count !== 16'd0 || dut_b.miss_count !== (STATS ? 16'd64 : 16'd0)) begin
            errors++;
            $display("FAIL conflict_totals: %0d cycles hit %0d miss %0d, required 448 0 %0d",
                     cyc, dut_b.hit_count, dut_b.miss_count, STATS ? 64 : 0);
        end
    endtask

    initial begin
        sel_b = 1'b0;
        test_reset();
        test_full_run();
        for (int r = 0; r < 3; r++) begin
            test_reset_mid_miss();
        end
        test_conflict();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
